// File: rtl/port_packer_if.sv
// Upstream word stream and switch-write port of one port_packer instance.
// slave: seen from the packer; master: seen from the logic driving it.
interface port_packer_if;
  logic        in_vld;
  logic [15:0] in_data;
  logic        in_last;
  logic [2:0]  in_prior;
  logic [3:0]  in_dest;
  logic        in_ready;
  logic        pause;
  logic        wr_sop;
  logic        wr_eop;
  logic        wr_vld;
  logic [15:0] wr_data;
  logic [15:0] drop_cnt;

  modport slave (
    input  in_vld, in_data, in_last, in_prior, in_dest, pause,
    output in_ready, wr_sop, wr_eop, wr_vld, wr_data, drop_cnt
  );

  modport master (
    output in_vld, in_data, in_last, in_prior, in_dest, pause,
    input  in_ready, wr_sop, wr_eop, wr_vld, wr_data, drop_cnt
  );
endinterface

// File: rtl/port_packer.sv
// Store-and-forward packer: buffers one packet (31..511 words) and replays it as sop/header/data/eop.
// Define PORT_PACKER_DROP_CNT_EN to build the saturating dropped-packet counter; otherwise drop_cnt is 0.
module port_packer (
  input  logic         clk,
  input  logic         rst,
  port_packer_if.slave bus
);

  localparam int unsigned MIN_LEN = 31;

  typedef enum logic [2:0] {
    S_FILL, S_DROP, S_ARB, S_SOP, S_HDR, S_DATA, S_EOP
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  wcnt_q, wcnt_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  rcnt_q, rcnt_d;
  logic [2:0]  prior_q, prior_d;
  logic [3:0]  dest_q, dest_d;
  logic        wr_sop_q, wr_sop_d;
  logic        wr_eop_q, wr_eop_d;
  logic        wr_vld_q, wr_vld_d;
  logic [15:0] wr_data_q, wr_data_d;

  logic [15:0] mem [512];
  logic [15:0] rd_word;
  logic        accept;
  logic        mem_we;
  logic        drop_evt;

  assign bus.in_ready = ~rst & ((state_q == S_FILL) | (state_q == S_DROP));
  assign accept       = bus.in_vld & bus.in_ready;
  assign mem_we       = accept & (state_q == S_FILL);
  assign rd_word      = mem[rcnt_q];

  // NOTE: the buffer has no reset; every word replayed was written by the packet being replayed.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wcnt_q] <= bus.in_data;
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    len_d    = len_q;
    rcnt_d   = '0;
    prior_d  = prior_q;
    dest_d   = dest_q;
    drop_evt = 1'b0;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          if (wcnt_q == '0) begin
            prior_d = bus.in_prior;
            dest_d  = bus.in_dest;
          end
          if (bus.in_last) begin
            wcnt_d = '0;
            // Lengths outside 31..511 are discarded; 512 cannot be encoded in the header.
            if (wcnt_q >= 9'(MIN_LEN - 1) && wcnt_q != 9'd511) begin
              state_d = S_ARB;
              len_d   = wcnt_q + 9'd1;
            end else begin
              drop_evt = 1'b1;
            end
          end else if (wcnt_q == 9'd511) begin
            state_d = S_DROP;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 9'd1;
          end
        end
      end
      S_DROP: begin
        if (accept && bus.in_last) begin
          state_d  = S_FILL;
          drop_evt = 1'b1;
        end
      end
      S_ARB:  if (!bus.pause) state_d = S_SOP;
      S_SOP:  state_d = S_HDR;
      S_HDR: begin
        // Word 0 is read here so the first DATA cycle already carries it.
        state_d = S_DATA;
        rcnt_d  = 9'd1;
      end
      S_DATA: begin
        if (rcnt_q == len_q) state_d = S_EOP;
        else                 rcnt_d  = rcnt_q + 9'd1;
      end
      S_EOP: begin
        state_d = S_FILL;
        wcnt_d  = '0;
      end
      default: state_d = S_FILL;
    endcase

    // Strobes are decoded from the next state so they are registered yet aligned with it.
    wr_sop_d  = (state_d == S_SOP);
    wr_vld_d  = (state_d == S_HDR) | (state_d == S_DATA);
    wr_eop_d  = (state_d == S_EOP);
    wr_data_d = wr_data_q;
    if (state_d == S_HDR)       wr_data_d = {len_q, prior_q, dest_q};
    else if (state_d == S_DATA) wr_data_d = rd_word;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FILL;
      wcnt_q    <= '0;
      len_q     <= '0;
      rcnt_q    <= '0;
      prior_q   <= '0;
      dest_q    <= '0;
      wr_sop_q  <= 1'b0;
      wr_eop_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      len_q     <= len_d;
      rcnt_q    <= rcnt_d;
      prior_q   <= prior_d;
      dest_q    <= dest_d;
      wr_sop_q  <= wr_sop_d;
      wr_eop_q  <= wr_eop_d;
      wr_vld_q  <= wr_vld_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_sop  = wr_sop_q;
  assign bus.wr_eop  = wr_eop_q;
  assign bus.wr_vld  = wr_vld_q;
  assign bus.wr_data = wr_data_q;

`ifdef PORT_PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_evt && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
  assign bus.drop_cnt    = '0;
`endif

endmodule
